// File: rtl/serial_detect_arbiter_if.sv
// Bundle between the four requesters, the shared two-ones detector and the arbiter.
// slave is the arbiter's view; master is the requester/detector side.
interface serial_detect_arbiter_if #(
  parameter int CW = 4
);
  logic [3:0]    req;
  logic [3:0]    w_in;
  logic [3:0]    gnt;
  logic          det_w;
  logic          det_clr;
  logic          det_z;
  logic          busy;
  logic          done;
  logic [1:0]    done_id;
  logic [CW-1:0] hit_cnt;

  modport master (
    output req, w_in, det_z,
    input  gnt, det_w, det_clr, busy, done, done_id, hit_cnt
  );

  modport slave (
    input  req, w_in, det_z,
    output gnt, det_w, det_clr, busy, done, done_id, hit_cnt
  );
endinterface

// File: rtl/serial_detect_arbiter.sv
// Round-robin arbiter that streams BURST serial bits from the granted requester
// through a shared two-consecutive-ones detector and reports the hit count.
module serial_detect_arbiter #(
  parameter int BURST = 8,
  parameter int CW    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  serial_detect_arbiter_if.slave bus,
  output logic [2:0]            dbg_state_o
);

  localparam int KW = (BURST > 2) ? $clog2(BURST) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q;
  logic [1:0]    sel_q;
  logic [1:0]    last_id_q;
  logic [KW-1:0] k_q;
  logic [CW-1:0] acc_q;
  logic [3:0]    gnt_q;
  logic          busy_q;
  logic          done_q;
  logic          det_clr_q;
  logic [1:0]    done_id_q;
  logic [CW-1:0] hit_cnt_q;

  logic [1:0]    winner_d;
  logic [1:0]    cand_d;
  logic          found_d;

  // Handshake: req is level-sensitive with no ready; a requester is served when
  // gnt shows its bit and the burst ends on the single-cycle done pulse, so
  // nothing about req outside IDLE influences the FSM.
  always_comb begin
    winner_d = 2'd0;
    cand_d   = 2'd0;
    found_d  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand_d = last_id_q + 2'(i + 1);
      if (!found_d && bus.req[cand_d]) begin
        winner_d = cand_d;
        found_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= 2'd0;
      last_id_q <= 2'd3;
      k_q       <= '0;
      acc_q     <= '0;
      gnt_q     <= 4'b0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      det_clr_q <= 1'b0;
      done_id_q <= 2'd0;
      hit_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (found_d) begin
            sel_q     <= winner_d;
            gnt_q     <= 4'b0001 << winner_d;
            busy_q    <= 1'b1;
            det_clr_q <= 1'b1;
            state_q   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          acc_q     <= '0;
          k_q       <= '0;
          det_clr_q <= 1'b0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          // det_z at k=0 still reflects the freshly cleared detector.
          if ((k_q != '0) && bus.det_z) begin
            acc_q <= acc_q + CW'(1);
          end
          if (k_q == K_LAST) begin
            state_q <= S_DRAIN;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        S_DRAIN: begin
          gnt_q     <= 4'b0000;
          done_q    <= 1'b1;
          done_id_q <= sel_q;
          hit_cnt_q <= acc_q + CW'(bus.det_z);
          state_q   <= S_DONE;
        end
        S_DONE: begin
          last_id_q <= sel_q;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;
  assign bus.hit_cnt = hit_cnt_q;
  assign bus.det_clr = det_clr_q | reset;
  assign bus.det_w   = (state_q == S_RUN) ? bus.w_in[sel_q] : 1'b0;
  assign dbg_state_o = state_q;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.gnt));
  a_det_w_run_only : assert property (@(posedge clk) disable iff (reset)
    (state_q != S_RUN) |-> !bus.det_w);
  a_busy_matches_state : assert property (@(posedge clk) disable iff (reset)
    bus.busy == (state_q != S_IDLE));

endmodule

// File: tb/tb_serial_detect_arbiter.sv
// Directed bench for serial_detect_arbiter with a behavioural two-ones detector.
module tb_serial_detect_arbiter;

  localparam int BURST = 8;
  localparam int CW    = 4;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;
  logic       det_prev;
  logic       det_zq;
  int         n_total;
  int         n_bad;

  serial_detect_arbiter_if #(.CW(CW)) bus ();

  serial_detect_arbiter #(.BURST(BURST), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Moore detector: z is high when the two most recent bits were both one.
  initial begin
    det_prev = 1'b0;
    det_zq   = 1'b0;
  end
  always @(posedge clk) begin
    if (bus.det_clr) begin
      det_prev <= 1'b0;
      det_zq   <= 1'b0;
    end else begin
      det_zq   <= det_prev & bus.det_w;
      det_prev <= bus.det_w;
    end
  end
  assign bus.det_z = det_zq;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the IDLE cycle where req is sampled; returns in the IDLE cycle after DONE.
  task automatic run_burst(input logic [3:0] r_set, input logic [1:0] id,
                           input logic [7:0] bits, input logic [3:0] exp_hits,
                           input logic [3:0] drop_mask);
    logic [3:0] g;
    g = 4'b0001 << id;
    bus.req  = r_set;
    bus.w_in = 4'b0000;
    step();
    check($sformatf("clear_gnt id%0d", id), 32'(bus.gnt), 32'(g));
    check("clear_det_clr", 32'(bus.det_clr), 32'd1);
    check("clear_det_w", 32'(bus.det_w), 32'd0);
    check("clear_busy", 32'(bus.busy), 32'd1);
    check("clear_state", 32'(dbg_state), 32'd1);
    for (int k = 0; k < BURST; k++) begin
      step();
      if (k == 3) bus.req = bus.req & ~drop_mask;
      bus.w_in = bits[k] ? g : ~g;
      #1;
      check($sformatf("run_gnt id%0d k%0d", id, k), 32'(bus.gnt), 32'(g));
      check($sformatf("run_det_w k%0d", k), 32'(bus.det_w), 32'(bits[k]));
      check("run_det_clr", 32'(bus.det_clr), 32'd0);
      check("run_state", 32'(dbg_state), 32'd2);
      check("run_done", 32'(bus.done), 32'd0);
    end
    step();
    bus.w_in = 4'b1111;
    #1;
    check("drain_gnt", 32'(bus.gnt), 32'(g));
    check("drain_det_w", 32'(bus.det_w), 32'd0);
    check("drain_state", 32'(dbg_state), 32'd3);
    step();
    check("done_gnt", 32'(bus.gnt), 32'd0);
    check("done_pulse", 32'(bus.done), 32'd1);
    check($sformatf("done_id exp%0d", id), 32'(bus.done_id), 32'(id));
    check($sformatf("hit_cnt id%0d", id), 32'(bus.hit_cnt), 32'(exp_hits));
    check("done_busy", 32'(bus.busy), 32'd1);
    check("done_state", 32'(dbg_state), 32'd4);
    step();
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_gnt", 32'(bus.gnt), 32'd0);
    check("idle_hit_hold", 32'(bus.hit_cnt), 32'(exp_hits));
    check("idle_state", 32'(dbg_state), 32'd0);
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    reset    = 1'b1;
    bus.req  = 4'b0000;
    bus.w_in = 4'b0000;

    // reset for two cycles
    step();
    step();
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hit_cnt", 32'(bus.hit_cnt), 32'd0);
    check("rst_done_id", 32'(bus.done_id), 32'd0);
    check("rst_det_clr", 32'(bus.det_clr), 32'd1);
    reset = 1'b0;
    #1;
    check("rel_det_clr", 32'(bus.det_clr), 32'd0);
    step();
    check("rel_gnt", 32'(bus.gnt), 32'd0);
    check("rel_busy", 32'(bus.busy), 32'd0);
    check("rel_state", 32'(dbg_state), 32'd0);
    check("rel_det_clr2", 32'(bus.det_clr), 32'd0);

    // single request, all ones: pairs (k-2,k-1) for k=2..7 plus drain = 7
    run_burst(4'b0100, 2'd2, 8'b1111_1111, 4'd7, 4'b0100);
    // single request, bits 1,1,0,1,1,1,0,0 (bit k at position k)
    run_burst(4'b0001, 2'd0, 8'b0011_1011, 4'd3, 4'b0001);

    // all four from reset, held high
    reset   = 1'b1;
    bus.req = 4'b1111;
    step();
    step();
    check("rr_rst_gnt", 32'(bus.gnt), 32'd0);
    reset = 1'b0;
    run_burst(4'b1111, 2'd0, 8'b1111_0000, 4'd3, 4'b0000);
    run_burst(4'b1111, 2'd1, 8'b0000_1111, 4'd3, 4'b0000);
    run_burst(4'b1111, 2'd2, 8'b1010_1010, 4'd0, 4'b0000);
    run_burst(4'b1111, 2'd3, 8'b1100_0011, 4'd2, 4'b0000);
    run_burst(4'b1111, 2'd0, 8'b0111_1110, 4'd5, 4'b0000);

    // requesters 1 and 3 alternate; 1 drops req mid-burst
    run_burst(4'b1010, 2'd1, 8'b0000_0000, 4'd0, 4'b0000);
    run_burst(4'b1010, 2'd3, 8'b1111_1111, 4'd7, 4'b0000);
    run_burst(4'b1010, 2'd1, 8'b0111_1110, 4'd5, 4'b0010);
    run_burst(4'b1000, 2'd3, 8'b0011_1011, 4'd3, 4'b0000);
    bus.req = 4'b0000;

    // reset during RUN k=4 of requester 1
    reset   = 1'b1;
    bus.req = 4'b0010;
    step();
    step();
    reset = 1'b0;
    step();
    check("mid_clear_gnt", 32'(bus.gnt), 32'b0010);
    for (int i = 0; i < 5; i++) step();
    check("mid_run_state", 32'(dbg_state), 32'd2);
    check("mid_run_gnt", 32'(bus.gnt), 32'b0010);
    reset = 1'b1;
    step();
    check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_hit", 32'(bus.hit_cnt), 32'd0);
    check("mid_rst_det_clr", 32'(bus.det_clr), 32'd1);
    reset = 1'b0;
    run_burst(4'b1111, 2'd0, 8'b1111_1111, 4'd7, 4'b0000);
    bus.req = 4'b0000;
    step();
    check("end_done", 32'(bus.done), 32'd0);
    check("end_busy", 32'(bus.busy), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_detect_arbiter.md
SERIAL_DETECT_ARBITER -- requirements
Module: serial_detect_arbiter

Interface
REQ-001 SHALL have parameter BURST, default 8, meaning bits streamed per grant (legal range 2..15).
REQ-002 SHALL have parameter CW, default 4, meaning hit_cnt width, equal to ceil(log2(BURST+1)).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester request, level-sensitive.
REQ-006 w_in  input  4  per-requester serial data bit.
REQ-007 gnt  output  4  one-hot grant; all zeros when no grant.
REQ-008 det_w  output  1  serial bit forwarded to the shared two-consecutive-ones detector.
REQ-009 det_clr  output  1  clear to the shared detector; the detector returns to its initial state.
REQ-010 det_z  input  1  shared detector output (Moore; reflects bits up to the previous cycle).
REQ-011 busy  output  1  high in every non-IDLE state.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 done_id  output  2  index of the requester whose burst completed.
REQ-014 hit_cnt  output  CW  count of det_z-high cycles for the completed burst.

Function
REQ-015 SHALL implement a state machine with states IDLE, CLEAR, RUN, DRAIN and DONE.
REQ-016 IDLE -> CLEAR when any req bit is high; otherwise the FSM stays in IDLE.
- Winner chosen round-robin: search starts at last_id+1 mod 4, first set req bit wins.
- Winner registered into sel.
REQ-017 CLEAR lasts 1 cycle: gnt[sel]=1, det_clr=1, det_w=0; then -> RUN.
REQ-018 RUN lasts exactly BURST cycles, tracked by bit counter k=0..BURST-1.
- gnt[sel]=1, det_w=w_in[sel].
- Transition to DRAIN after k=BURST-1.
REQ-019 DRAIN lasts 1 cycle: gnt[sel]=1, det_w=0; then -> DONE.
REQ-020 DONE lasts 1 cycle: gnt=0, done=1, done_id=sel, last_id<=sel; then -> IDLE.
REQ-021 Hit accumulator:
- Cleared in CLEAR.
- Increments on det_z=1 in RUN cycles with k>=1 and in the DRAIN cycle.
- det_z is ignored in all other states.
REQ-022 hit_cnt SHALL update to the accumulator value in DONE and hold until the next DONE; the accumulator never wraps (maximum BURST <= 2^CW-1).
REQ-023 gnt SHALL be one-hot or zero in every cycle, and SHALL remain on sel for the whole CLEAR..DRAIN window.
REQ-024 Deassertion of req[sel] mid-burst SHALL NOT shorten the burst; w_in[sel] is still forwarded to completion.
REQ-025 Changes to req during a burst SHALL be ignored; arbitration occurs only in IDLE.
REQ-026 Latency, with req sampled high in IDLE at cycle t:
- CLEAR at t+1.
- RUN at t+2..t+1+BURST.
- DRAIN at t+2+BURST.
- done at t+3+BURST.
REQ-027 Back-to-back bursts SHALL be separated by exactly one IDLE cycle.
REQ-028 det_clr SHALL be 0 outside CLEAR and reset; det_w SHALL be 0 outside RUN.

Reset
REQ-029 While reset=1 at a clock edge:
- FSM -> IDLE, with gnt=0, busy=0, done=0, done_id=0, hit_cnt=0.
- Accumulator and bit counter cleared; last_id=3, so requester 0 has first priority.
REQ-030 det_clr SHALL be 1 while reset is high.
REQ-031 Reset SHALL take precedence over all transitions, including mid-RUN; an aborted burst produces no done pulse.

Verification
REQ-032 Assert reset for 2 cycles -> gnt=0, busy=0, done=0, hit_cnt=0, det_clr=1; after release, outputs are idle and det_clr=0.
REQ-033 Single-request all-ones burst:
- Stimulus: req=0100 at cycle t, w_in[2]=1 for all 8 RUN bits, behavioral detector attached.
- Response: gnt=0100 for t+1..t+10, done at t+11 with done_id=2 and hit_cnt=7.
REQ-034 Single-request patterned burst:
- Stimulus: req[0] only, bits 1,1,0,1,1,1,0,0.
- Response: hit_cnt=3, done_id=0.
REQ-035 All four requests from reset, held high -> grant order 0,1,2,3,0; one-hot gnt checked every cycle; 12-cycle burst period.
REQ-036 req[1] and req[3] held high -> done_id alternates 1,3,1,3; requester 1 drops req mid-burst -> its burst still completes in full.
REQ-037 Mid-burst reset:
- Stimulus: reset asserted at RUN k=4 of requester 1.
- Response: next cycle gnt=0, busy=0, no done pulse.
- After release with req=1111: first grant goes to requester 0.
